lmc1992_mw_rx: RTL
==================

Name: lmc1992_mw_rx

Overview:
- Microwire receiver and decoder emulating the LMC1992 volume/tone controller at the far end of the STE microwire link.
- Samples the serial clock, data and enable lines from the microwire master and shifts in command frames.
- Decodes and range-checks each frame, then holds the resulting mixer, bass, treble and volume settings.
- Derives a per-channel total attenuation for the downstream audio mixer.

Parameters:
- MIN_BITS, 11, minimum bits in a frame for it to be decoded.
- DEV_ADDR, 2'b10, device address expected in frame bits [10:9].

Ports:
- clk  in  1  system clock (8 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- mw_clk  in  1  microwire bit clock, asynchronous; data sampled on its rising edge.
- mw_data  in  1  microwire serial data, MSB first.
- mw_en_n  in  1  microwire enable, active low; a rising edge ends the frame.
- mix  out  2  mixing mode: 00 = -12 dB, 01 = mix GI, 10 = no mix, 11 = reserved.
- bass  out  4  bass setting, 0..12; 6 = flat.
- treble  out  4  treble setting, 0..12; 6 = flat.
- master_vol  out  6  master volume, 0..40; 40 = 0 dB, 2 dB per step.
- left_vol  out  5  left volume, 0..20; 20 = 0 dB.
- right_vol  out  5  right volume, 0..20.
- atten_l  out  7  total left attenuation in dB: (40-master_vol)*2 + (20-left_vol)*2.
- atten_r  out  7  total right attenuation in dB, same formula with right_vol.
- upd  out  1  one-clk pulse when a register is written.
- frm_err  out  1  one-clk pulse when a frame is discarded.

Behaviour:
- Reset values: mix = 01, bass = 6, treble = 6, master_vol = 40, left_vol = 20, right_vol = 20, atten_l = atten_r = 0, upd = 0, frm_err = 0. The shift register and bit counter are cleared.
- Input sync: mw_clk, mw_data and mw_en_n each pass through a 2-flop synchronizer. Edges are detected on the synchronized signals by comparing with a third flop.
- FSM has two states, IDLE and SHIFT:
  - IDLE: a synchronized falling edge on mw_en_n goes to SHIFT and clears the bit counter and shift register.
  - SHIFT: each synchronized mw_clk rising edge shifts the synchronized data in, {sr[9:0], d}, into an 11-bit register. The bit counter increments and saturates at 31.
  - SHIFT: a mw_en_n rising edge returns to IDLE and triggers evaluation in the same cycle.
  - A mw_clk edge and a mw_en_n rising edge detected in the same cycle: the shift happens first and the shifted value is evaluated.
- Evaluation: the frame is the last 11 bits shifted.
  - count < MIN_BITS, or sr[10:9] != DEV_ADDR → discard, frm_err pulse.
  - Function field sr[8:6], data field sr[5:0]:
    - 000 → mix = d[1:0].
    - 001 → bass = d[3:0], clamped to 12.
    - 010 → treble = d[3:0], clamped to 12.
    - 011 → master_vol = d[5:0], clamped to 40.
    - 100 → right_vol = d[4:0], clamped to 20.
    - 101 → left_vol = d[4:0], clamped to 20.
    - 110 and 111 → discard, frm_err pulse.
  - Unused upper data bits are ignored.
  - A valid write produces an upd pulse in the same cycle the register is updated.
- Latency: a register updates on the clk edge 3 cycles after the raw mw_en_n rises (2 sync + 1 edge detect). atten_l and atten_r update one clk after that, as a registered subtract/shift. Widths: 80 + 40 = 120 fits in 7 bits.
- mw_clk edges in IDLE are ignored. mw_en_n held low indefinitely keeps the FSM in SHIFT; the saturating counter prevents wrap.
- A mw_en_n falling edge while already in SHIFT restarts the frame: counter and shift register are cleared.
- reset_n low mid-frame aborts the frame immediately and asynchronously restores all reset values. No upd or frm_err is produced.

Decomposition:
- Package lmc_pkg:
  - Function code constants: FN_MIX, FN_BASS, FN_TREBLE, FN_MASTER, FN_RIGHT, FN_LEFT.
  - Max constants: 12, 40, 20.
  - Reset-value constants.
  - FSM state enum: IDLE, SHIFT.
- Sub-module mw_sync: 2-flop synchronizer plus edge detector, instantiated once per input line. Outputs the synchronized level, rise pulse and fall pulse.

Test Plan:
- After reset → mix = 01, bass = 6, treble = 6, master_vol = 40, left_vol = right_vol = 20, atten_l = atten_r = 0.
- Frame 10_011_010100 (master = 20), then en rises → master_vol = 20, atten_l = 40, upd pulse; no other register changes.
- Frame 10_101_011111 (left = 31) → left_vol = 20 (clamped), upd pulse. Frame 10_001_001111 → bass = 12.
- 10-bit frame, or address 01, or function 110 → no register change, one frm_err pulse each.
- 14-bit frame with the last 11 bits = 10_100_000101 → right_vol = 5, atten_r = 30.
- reset_n asserted after 5 bits, then released and a valid treble = 3 frame sent → treble = 3, no stale bits; the mid-frame reset itself produces no upd or frm_err.

Source files
------------

// File: rtl/lmc1992_mw_rx_pkg.sv
// Shared constants, FSM state type and attenuation helper for the LMC1992 microwire receiver.
package lmc_pkg;

  localparam logic [2:0] FN_MIX    = 3'd0;
  localparam logic [2:0] FN_BASS   = 3'd1;
  localparam logic [2:0] FN_TREBLE = 3'd2;
  localparam logic [2:0] FN_MASTER = 3'd3;
  localparam logic [2:0] FN_RIGHT  = 3'd4;
  localparam logic [2:0] FN_LEFT   = 3'd5;

  localparam logic [3:0] TONE_MAX   = 4'd12;
  localparam logic [5:0] MASTER_MAX = 6'd40;
  localparam logic [4:0] SIDE_MAX   = 5'd20;

  localparam logic [1:0] MIX_RST    = 2'b01;
  localparam logic [3:0] TONE_RST   = 4'd6;
  localparam logic [5:0] MASTER_RST = 6'd40;
  localparam logic [4:0] SIDE_RST   = 5'd20;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Operands are always clamped, so neither subtraction can underflow.
  function automatic logic [6:0] atten_calc(input logic [5:0] master, input logic [4:0] side);
    logic [6:0] m_db;
    logic [6:0] s_db;
    m_db = (7'd40 - {1'b0, master}) << 1;
    s_db = (7'd20 - {2'b00, side}) << 1;
    return m_db + s_db;
  endfunction

endpackage

// File: rtl/lmc1992_mw_rx_sync.sv
// Two-flop synchronizer with a third flop for edge detection on one microwire line.
module mw_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [2:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= {3{INIT}};
    else          q <= {q[1:0], raw};
  end

  assign lvl  = q[1];
  assign rise = q[1] & ~q[2];
  assign fall = ~q[1] & q[2];

endmodule

// File: rtl/lmc1992_mw_rx.sv
// LMC1992 emulation: shifts in microwire frames, range-checks and decodes them into
// mixer/tone/volume registers, and derives registered per-channel total attenuation.
module lmc1992_mw_rx
  import lmc_pkg::*;
#(
  parameter int         MIN_BITS = 11,
  parameter logic [1:0] DEV_ADDR = 2'b10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_en_n,
  output logic [1:0] mix,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [6:0] atten_l,
  output logic [6:0] atten_r,
  output logic       upd,
  output logic       frm_err
);

  localparam logic [4:0] MIN_CNT = 5'(MIN_BITS);

  logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;
  logic sdat, sdat_rise_unused, sdat_fall_unused;
  logic sen_lvl_unused, sen_rise, sen_fall;

  mw_sync #(.INIT(1'b0)) u_sync_clk (.clk(clk), .reset_n(reset_n), .raw(mw_clk),
    .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused));
  mw_sync #(.INIT(1'b0)) u_sync_dat (.clk(clk), .reset_n(reset_n), .raw(mw_data),
    .lvl(sdat), .rise(sdat_rise_unused), .fall(sdat_fall_unused));
  // Enable idles high, so its synchronizer must reset high to avoid a phantom frame start.
  mw_sync #(.INIT(1'b1)) u_sync_en (.clk(clk), .reset_n(reset_n), .raw(mw_en_n),
    .lvl(sen_lvl_unused), .rise(sen_rise), .fall(sen_fall));

  state_t      state, state_n;
  logic [10:0] sr, sr_n, sr_sh;
  logic [4:0]  cnt, cnt_n, cnt_sh;
  logic        eval, wr, err;
  logic [2:0]  fn;
  logic [5:0]  d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
    end
  end

  // The shifted value feeds evaluation so a clock edge coincident with enable rise counts.
  assign sr_sh  = sclk_rise ? {sr[9:0], sdat} : sr;
  assign cnt_sh = (sclk_rise && cnt != 5'd31) ? cnt + 5'd1 : cnt;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    eval    = 1'b0;
    case (state)
      IDLE: begin
        if (sen_fall) begin
          state_n = SHIFT;
          sr_n    = '0;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (sen_fall) begin
          sr_n  = '0;
          cnt_n = '0;
        end else begin
          sr_n  = sr_sh;
          cnt_n = cnt_sh;
          if (sen_rise) begin
            state_n = IDLE;
            eval    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign fn  = sr_sh[8:6];
  assign d   = sr_sh[5:0];
  assign wr  = eval && (cnt_sh >= MIN_CNT) && (sr_sh[10:9] == DEV_ADDR) && (fn <= FN_LEFT);
  assign err = eval && !wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mix        <= MIX_RST;
      bass       <= TONE_RST;
      treble     <= TONE_RST;
      master_vol <= MASTER_RST;
      left_vol   <= SIDE_RST;
      right_vol  <= SIDE_RST;
      atten_l    <= '0;
      atten_r    <= '0;
      upd        <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      upd     <= wr;
      frm_err <= err;
      atten_l <= atten_calc(master_vol, left_vol);
      atten_r <= atten_calc(master_vol, right_vol);
      if (wr) begin
        case (fn)
          FN_MIX:    mix        <= d[1:0];
          FN_BASS:   bass       <= (d[3:0] > TONE_MAX)   ? TONE_MAX   : d[3:0];
          FN_TREBLE: treble     <= (d[3:0] > TONE_MAX)   ? TONE_MAX   : d[3:0];
          FN_MASTER: master_vol <= (d[5:0] > MASTER_MAX) ? MASTER_MAX : d[5:0];
          FN_RIGHT:  right_vol  <= (d[4:0] > SIDE_MAX)   ? SIDE_MAX   : d[4:0];
          FN_LEFT:   left_vol   <= (d[4:0] > SIDE_MAX)   ? SIDE_MAX   : d[4:0];
          default:   ;
        endcase
      end
    end
  end

endmodule
